// File: rtl/l1_trig_scaler_bank.sv
// Per-channel L1 trigger scaler bank with gated latching into a holding bank.
// Wishbone slave exposes holding counts, CONTROL and PERIOD registers.
module l1_trig_scaler_bank #(
    parameter int          NCHAN       = 48,
    parameter int          CNT_WIDTH   = 24,
    parameter logic [31:0] PERIOD_INIT = 32'd99999999
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [NCHAN-1:0] trig_i,
    output logic             trig_count_done_o,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [21:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o
);

    localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] live_q [NCHAN];
    logic [CNT_WIDTH-1:0] live_d [NCHAN];
    logic [CNT_WIDTH-1:0] hold_q [NCHAN];
    logic [CNT_WIDTH-1:0] hold_d [NCHAN];
    logic [CNT_WIDTH-1:0] sum    [NCHAN];
    logic [31:0]          period_q, period_d;
    logic [31:0]          gate_q, gate_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          rdata;
    logic                 enable_q, enable_d;
    logic                 done_q, done_d;
    logic                 ack_q, ack_d;
    logic                 req, wr, latch, regsel;
    logic [5:0]           idx;
    logic                 unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[21:9], wb_adr_i[1:0]};

    always_comb begin
        req      = wb_cyc_i & wb_stb_i & ~ack_q;
        wr       = req & wb_we_i;
        regsel   = wb_adr_i[8];
        idx      = wb_adr_i[7:2];
        latch    = enable_q && (gate_q == 32'd0);
        enable_d = enable_q;
        period_d = period_q;
        if (wr && regsel && idx == 6'd0) enable_d = wb_dat_i[0];
        if (wr && regsel && idx == 6'd1) period_d = wb_dat_i;

        // Disabled gate sits at PERIOD so enabling starts a full gate.
        if (!enable_q || latch) gate_d = period_q;
        else                    gate_d = gate_q - 32'd1;

        for (int i = 0; i < NCHAN; i++) begin
            sum[i] = (trig_i[i] && live_q[i] != CMAX) ?
                     live_q[i] + 1'b1 : live_q[i];
            live_d[i] = (!enable_q || latch) ? '0 : sum[i];
            hold_d[i] = latch ? sum[i] : hold_q[i];
        end
        done_d = latch;
        ack_d  = req;

        rdata = 32'd0;
        if (!regsel) begin
            if ({26'd0, idx} < NCHAN) rdata = 32'(hold_q[idx]);
        end else if (idx == 6'd0) begin
            rdata = {30'd0, enable_q, enable_q};
        end else if (idx == 6'd1) begin
            rdata = period_q;
        end
        dat_d = req ? rdata : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < NCHAN; i++) begin
                live_q[i] <= '0;
                hold_q[i] <= '0;
            end
            enable_q <= 1'b0;
            period_q <= PERIOD_INIT;
            gate_q   <= PERIOD_INIT;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                live_q[i] <= live_d[i];
                hold_q[i] <= hold_d[i];
            end
            enable_q <= enable_d;
            period_q <= period_d;
            gate_q   <= gate_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign trig_count_done_o = done_q;
    assign wb_ack_o          = ack_q;
    assign wb_dat_o          = dat_q;
    assign wb_err_o          = 1'b0;
    assign wb_rty_o          = 1'b0;

endmodule

// File: tb/tb_l1_trig_scaler_bank.sv
// Bench for l1_trig_scaler_bank: directed and random trigger traffic
// checked against a gate-window model of the scaler bank.
module tb_l1_trig_scaler_bank;

    localparam int          NCH  = 48;
    localparam int          SMAX = 15;
    localparam logic [31:0] PINIT = 32'd99999999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] trig;
    logic        cyc, stb, we;
    logic [21:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack, err, rty, done;

    int checks = 0;
    int errors = 0;

    // Model: gate position counts up from 0 to the gate's period.
    bit          m_en;
    bit          m_done;
    int unsigned m_period, m_len, m_pos;
    int          m_sum  [NCH];
    int          m_hold [NCH];
    bit          rnd;
    logic [47:0] cur_trig;

    l1_trig_scaler_bank #(
        .NCHAN      (48),
        .CNT_WIDTH  (4),
        .PERIOD_INIT(PINIT)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_ni        (rst_n),
        .trig_i           (trig),
        .trig_count_done_o(done),
        .wb_cyc_i         (cyc),
        .wb_stb_i         (stb),
        .wb_we_i          (we),
        .wb_adr_i         (adr),
        .wb_dat_i         (dat_i),
        .wb_sel_i         (sel),
        .wb_dat_o         (dat_o),
        .wb_ack_o         (ack),
        .wb_err_o         (err),
        .wb_rty_o         (rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_en     = 1'b0;
        m_done   = 1'b0;
        m_period = PINIT;
        m_len    = PINIT;
        m_pos    = 0;
        for (int i = 0; i < NCH; i++) begin
            m_sum[i]  = 0;
            m_hold[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [21:0] a);
        int i;
        i = int'(a[7:2]);
        if (!a[8]) return (i < NCH) ? 32'(m_hold[i]) : 32'd0;
        if (i == 0) return {30'd0, m_en, m_en};
        if (i == 1) return m_period;
        return 32'd0;
    endfunction

    task automatic apply_write(input logic [21:0] a, input logic [31:0] d);
        if (a[8] && a[7:2] == 6'd0) begin
            if (!m_en && d[0]) begin
                m_pos = 0;
                m_len = m_period;
            end
            if (m_en && !d[0])
                for (int i = 0; i < NCH; i++) m_sum[i] = 0;
            m_en = d[0];
        end else if (a[8] && a[7:2] == 6'd1) begin
            m_period = d;
        end
    endtask

    task automatic tick(input bit wcommit);
        logic [47:0] t;
        t = rnd ? {16'($urandom), 32'($urandom)} : cur_trig;
        trig = t;
        @(posedge clk);
        m_done = 1'b0;
        if (m_en) begin
            for (int i = 0; i < NCH; i++) m_sum[i] += int'(t[i]);
            if (m_pos == m_len) begin
                for (int i = 0; i < NCH; i++) begin
                    m_hold[i] = (m_sum[i] > SMAX) ? SMAX : m_sum[i];
                    m_sum[i]  = 0;
                end
                m_pos  = 0;
                m_len  = m_period;
                m_done = 1'b1;
            end else begin
                m_pos++;
            end
        end
        if (wcommit) apply_write(adr, dat_i);
        @(negedge clk);
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        do begin
            tick(1'b0);
            n++;
        end while (!m_done && n < limit);
        chk("done_timeout", 32'(m_done), 32'd1);
    endtask

    task automatic wb_write(input logic [21:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
        tick(1'b1);
        chk("wr_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1'b0);
        chk("wr_ack_low", 32'(ack), 32'd0);
    endtask

    task automatic wb_read(input logic [21:0] a, input string tag);
        logic [31:0] exp;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        exp = m_read(a);
        tick(1'b0);
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk(tag, dat_o, exp);
        cyc = 1'b0; stb = 1'b0;
        tick(1'b0);
        chk({tag, "_acklow"}, 32'(ack), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        trig = '0;
        model_init();
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] e;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = 4'hF; trig = '0;
        rnd = 1'b0; cur_trig = '0;
        do_reset();
        chk("err_tie", 32'({err, rty}), 32'd0);
        wb_read(22'h104, "period_rst");
        wb_read(22'h100, "control_rst");
        wb_read(22'h014, "ch5_rst");

        // Seven pulses on channel 5 inside one 10-clock gate.
        wb_write(22'h104, 32'd9);
        wb_write(22'h100, 32'd1);
        cur_trig = 48'd1 << 5;
        run(7);
        cur_trig = '0;
        run_until_done(30);
        wb_read(22'h014, "ch5_seven");
        wb_read(22'h000, "ch0_zero");

        // Continuous channel 0 across gate boundaries.
        cur_trig = 48'd1;
        run_until_done(30);
        run_until_done(30);
        wb_read(22'h000, "ch0_full");
        run_until_done(30);
        wb_read(22'h000, "ch0_full2");

        // Saturation of a 4-bit counter.
        wb_write(22'h104, 32'd49);
        cur_trig = 48'd1 << 3;
        run_until_done(30);
        run(40);
        cur_trig = '0;
        run_until_done(60);
        wb_read(22'h00C, "ch3_sat");

        // PERIOD change mid-gate applies at the next reload.
        wb_write(22'h100, 32'd0);
        wb_write(22'h104, 32'd19);
        wb_write(22'h100, 32'd1);
        run(5);
        wb_write(22'h104, 32'd4);
        run(30);
        wb_read(22'h100, "control_on");
        wb_read(22'h104, "period_4");

        // Out-of-range index, aliasing, unmapped and ignored writes.
        wb_read(22'h0FC, "idx63");
        wb_read(22'h3FFE14, "alias_ch5");
        wb_read(22'h108, "unmapped");
        wb_write(22'h00C, 32'hFFFF);
        wb_read(22'h00C, "scaler_wr_ign");

        // Back-to-back strobes: ack 1,0,1.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 22'h00C;
        e = m_read(adr);
        tick(1'b0);
        chk("b2b_ack1", 32'(ack), 32'd1);
        chk("b2b_dat1", dat_o, e);
        tick(1'b0);
        chk("b2b_ack0", 32'(ack), 32'd0);
        e = m_read(adr);
        tick(1'b0);
        chk("b2b_ack2", 32'(ack), 32'd1);
        chk("b2b_dat2", dat_o, e);
        cyc = 1'b0; stb = 1'b0;
        tick(1'b0);

        // Strobe without cycle must not ack.
        stb = 1'b1;
        tick(1'b0);
        chk("stb_nocyc", 32'(ack), 32'd0);
        stb = 1'b0;

        // Disable mid-gate: no done pulse, holding retained.
        cur_trig = (48'd1 << 7) | (48'd1 << 3);
        run_until_done(30);
        run(2);
        wb_write(22'h100, 32'd0);
        run(30);
        wb_read(22'h01C, "ch7_kept");
        wb_read(22'h00C, "ch3_kept");
        cur_trig = '0;

        // PERIOD=0: one-clock gates.
        wb_write(22'h104, 32'd0);
        wb_write(22'h100, 32'd1);
        rnd = 1'b1;
        run(8);
        wb_read(22'h010, "p0_ch4");
        wb_read(22'h0BC, "p0_ch47");

        // Random periods and traffic.
        for (int k = 0; k < 6; k++) begin
            wb_write(22'h100, 32'd0);
            wb_write(22'h104, 32'($urandom_range(1, 12)));
            wb_write(22'h100, 32'd1);
            run(int'($urandom_range(10, 50)));
            for (int j = 0; j < 3; j++)
                wb_read(22'($urandom_range(0, 47) * 4), "rnd_ch");
        end
        rnd = 1'b0;
        cur_trig = '0;

        // Reset in the middle of a read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 22'h014;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        model_init();
        rst_n = 1'b1;
        tick(1'b0);
        chk("rst_mid_ack2", 32'(ack), 32'd0);
        chk("rst_mid_dat", dat_o, 32'd0);
        wb_read(22'h104, "period_rst2");
        wb_read(22'h100, "control_rst2");
        wb_read(22'h014, "ch5_rst2");
        run(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
